// File: rtl/zle_dec_if.sv
// Handshake bundle for the zero-run-length decoder.
// Token side (i_*) and value side (o_*) share one interface.
interface zle_dec_if;
  logic [3:0] i_d;
  logic       i_v;
  logic       i_b;
  logic [2:0] o_d;
  logic       o_v;
  logic       o_b;

  modport master (
    output i_d, i_v, o_b,
    input  i_b, o_d, o_v
  );

  modport slave (
    input  i_d, i_v, o_b,
    output i_b, o_d, o_v
  );
endinterface

// File: rtl/zle_dec.sv
// Zero-run-length token decoder: literals and 1..8-zero runs.
// Define ZLE_DEC_ERR_EN to drop literal-0 tokens and flag them on err.
module zle_dec (
  input  logic clock,
  input  logic reset,
`ifdef ZLE_DEC_ERR_EN
  output logic err,
`endif
  zle_dec_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LIT  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] tok_q, tok_d;
  logic [2:0] cnt_q, cnt_d;
  logic       i_b, o_v;
  logic [2:0] o_d;
`ifdef ZLE_DEC_ERR_EN
  logic       err_q, err_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tok_q   <= '0;
      cnt_q   <= '0;
`ifdef ZLE_DEC_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tok_q   <= tok_d;
      cnt_q   <= cnt_d;
`ifdef ZLE_DEC_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tok_d   = tok_q;
    cnt_d   = cnt_q;
`ifdef ZLE_DEC_ERR_EN
    err_d   = err_q;
`endif
    i_b     = 1'b1;
    o_v     = 1'b0;
    o_d     = 3'd0;
    unique case (state_q)
      S_IDLE: begin
        i_b = 1'b0;
        if (bus.i_v) begin
          if (bus.i_d[3]) begin
            cnt_d   = bus.i_d[2:0];
            state_d = S_RUN;
          end
`ifdef ZLE_DEC_ERR_EN
          else if (bus.i_d[2:0] == 3'd0) begin
            err_d = 1'b1;
          end
`endif
          else begin
            tok_d   = bus.i_d[2:0];
            state_d = S_LIT;
          end
        end
      end
      S_LIT: begin
        o_v = 1'b1;
        o_d = tok_q;
        if (!bus.o_b) state_d = S_IDLE;
      end
      S_RUN: begin
        o_v = 1'b1;
        // cnt holds zeros left minus one, so zero means last
        if (!bus.o_b) begin
          if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
          else state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.i_b = i_b;
  assign bus.o_v = o_v;
  assign bus.o_d = o_d;
`ifdef ZLE_DEC_ERR_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_zle_dec.sv
// Randomized bench for zle_dec against a token-expansion queue model.
// Build with ZLE_DEC_ERR_EN defined to cover the illegal-token flag.
module tb_zle_dec;
  logic clock = 1'b0;
  logic reset = 1'b0;

  zle_dec_if bus ();

`ifdef ZLE_DEC_ERR_EN
  logic err;
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  zle_dec dut (
    .clock (clock),
    .reset (reset),
`ifdef ZLE_DEC_ERR_EN
    .err   (err),
`endif
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // expected output values still owed by the decoder
  int unsigned q[$];
  bit          exp_err = 1'b0;
  logic [5:0]  obs, want;
  logic        acc;

  function automatic logic cur_err();
`ifdef ZLE_DEC_ERR_EN
    return err;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_token(input logic [3:0] d);
    if (d[3]) begin
      for (int k = 0; k <= int'(d[2:0]); k++) q.push_back(0);
    end else if (ERR_EN && d[2:0] == 3'd0) begin
      exp_err = 1'b1;
    end else begin
      q.push_back(int'(d[2:0]));
    end
  endfunction

  // drive one cycle, sample mid-cycle, advance the model
  task automatic step(input logic v, input logic [3:0] d,
                      input logic ob);
    int unsigned tmp;
    bus.i_v = v;
    bus.i_d = d;
    bus.o_b = ob;
    @(negedge clock);
    obs = {bus.i_b, bus.o_v, bus.o_d, cur_err()};
    if (q.size() != 0)
      want = {1'b1, 1'b1, 3'(q[0]), exp_err};
    else
      want = {1'b0, 1'b0, 3'd0, exp_err};
    acc = 1'b0;
    if (q.size() != 0) begin
      if (!ob) tmp = q.pop_front();
    end else if (v) begin
      acc = 1'b1;
      model_token(d);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.i_v = 1'b1;
    bus.i_d = 4'b0011;
    bus.o_b = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      obs = {bus.i_b, bus.o_v, bus.o_d, cur_err()};
      total++;
      if (obs !== 6'b0) begin
        bad++;
        $display("FAIL reset {ib,ov,od,err} got=%b want=%b", obs, 6'b0);
      end
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_literals();
    logic [3:0] toks [3];
    toks = '{4'd3, 4'd5, 4'd7};
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 2; c++) begin
        step(1'b1, toks[t], 1'b0);
        total++;
        if (obs !== want) begin
          bad++;
          $display("FAIL literal t=%0d c=%0d got=%b want=%b",
                   t, c, obs, want);
        end
      end
    end
    step(1'b0, 4'd0, 1'b0);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL literal drain got=%b want=%b", obs, want);
    end
  endtask

  task automatic test_runs();
    logic [3:0] runs [2];
    runs = '{4'b1111, 4'b1000};
    for (int r = 0; r < 2; r++) begin
      step(1'b1, runs[r], 1'b0);
      total++;
      if (obs !== want || !acc) begin
        bad++;
        $display("FAIL run_accept r=%0d got=%b want=%b", r, obs, want);
      end
      for (int c = 0; c < int'(runs[r][2:0]) + 2; c++) begin
        step(1'b0, 4'd0, 1'b0);
        total++;
        if (obs !== want) begin
          bad++;
          $display("FAIL run r=%0d c=%0d got=%b want=%b",
                   r, c, obs, want);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] obs_seq;
    int zeros;
    obs_seq = 8'b0000_1110;
    zeros = 0;
    step(1'b1, 4'b1010, 1'b0);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL stall_accept got=%b want=%b", obs, want);
    end
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 4'b0001, obs_seq[c]);
      if (obs[4] && !obs_seq[c] && obs[3:1] == 3'd0 && !acc) zeros++;
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL stall c=%0d got=%b want=%b", c, obs, want);
      end
    end
    total++;
    if (zeros !== 3) begin
      bad++;
      $display("FAIL stall_zero_count got=%0d want=3", zeros);
    end
    step(1'b0, 4'd0, 1'b0);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL stall_drain got=%b want=%b", obs, want);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'b1111, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL midrst_first got=%b want=%b", obs, want);
    end
    reset = 1'b0;
    #1;
    obs = {bus.i_b, bus.o_v, bus.o_d, cur_err()};
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL midrst_abort got=%b want=%b", obs, 6'b0);
    end
    q.delete();
    exp_err = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(c == 0, 4'b0110, 1'b0);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL midrst_after c=%0d got=%b want=%b", c, obs, want);
      end
    end
  endtask

  task automatic test_zero_lit();
    for (int c = 0; c < 4; c++) begin
      step(c == 0, 4'b0000, 1'b0);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL zero_lit c=%0d got=%b want=%b", c, obs, want);
      end
    end
    total++;
    if (cur_err() !== exp_err) begin
      bad++;
      $display("FAIL zero_lit_err got=%b want=%b", cur_err(), exp_err);
    end
    reset = 1'b0;
    #1;
    q.delete();
    exp_err = 1'b0;
    total++;
    if (cur_err() !== 1'b0) begin
      bad++;
      $display("FAIL zero_lit_clear got=%b want=0", cur_err());
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic       v, ob;
    logic [3:0] d;
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      d  = 4'($urandom_range(0, 15));
      ob = ($urandom_range(0, 3) == 0);
      step(v, d, ob);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL random c=%0d got=%b want=%b", c, obs, want);
      end
    end
  endtask

  initial begin
    bus.i_v = 1'b0;
    bus.i_d = 4'd0;
    bus.o_b = 1'b0;
    test_reset();
    test_literals();
    test_runs();
    test_stall();
    test_reset_mid();
    test_zero_lit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zle_dec.md
ZLE_DEC -- requirements
Module: zle_dec

Interface
REQ-001 Port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 Port i_d, input, 4 bits: encoded token.
REQ-004 Port i_v, input, 1 bit: token valid.
REQ-005 Port i_b, output, 1 bit: input back-pressure; 1 means the token is not taken this cycle.
REQ-006 Port o_d, output, 3 bits: decoded data value.
REQ-007 Port o_v, output, 1 bit: output valid.
REQ-008 Port o_b, input, 1 bit: output back-pressure; 1 means the value is not taken this cycle.
REQ-009 Port err, output, 1 bit, present only when ZLE_DEC_ERR_EN is defined: sticky illegal-token flag.

Function
REQ-010 Token format: i_d[3]=0 is a literal with value i_d[2:0]; i_d[3]=1 is a zero run of length i_d[2:0]+1, i.e. 1..8 zeros.
REQ-011 A transfer occurs on a rising clock edge when i_v=1 and i_b=0 (input side), or when o_v=1 and o_b=0 (output side).
REQ-012 State machine has three states: S_IDLE, S_LIT and S_RUN.
REQ-013 Registers are a 3-bit tok (literal value) and a 3-bit cnt (zeros remaining minus one).
REQ-014 S_IDLE: i_b=0, o_v=0, o_d=0.
- i_v=1 with a literal: tok<=i_d[2:0], next state S_LIT.
- i_v=1 with a run: cnt<=i_d[2:0], next state S_RUN.
- i_v=0: remain in S_IDLE.
REQ-015 S_LIT: i_b=1, o_v=1, o_d=tok.
- o_b=0: next state S_IDLE.
- o_b=1: hold state and registers.
REQ-016 S_RUN: i_b=1, o_v=1, o_d=0.
- o_b=0 and cnt!=0: cnt<=cnt-1, stay in S_RUN.
- o_b=0 and cnt==0: next state S_IDLE.
- o_b=1: hold state and registers.
REQ-017 Latency: a token accepted at edge N presents its first output in the cycle after edge N, with o_v=1.
REQ-018 A run of length L with o_b held at 0 produces exactly L consecutive zero transfers, then one S_IDLE cycle.
REQ-019 Throughput: at most one token every two cycles; at most one output value per cycle.
REQ-020 o_d, o_v and i_b are combinational functions of state and registers only; no path from i_v or o_b to any output.
REQ-021 While o_v=1 and o_b=1, o_d stays stable until the transfer completes.
REQ-022 cnt never wraps: decrement occurs only when cnt!=0.
REQ-023 Any unused state encoding behaves as S_IDLE on the next edge: o_v=0, i_b=1 in that cycle.

Reset
REQ-024 While reset=0: state=S_IDLE, tok=0, cnt=0, err=0 (when present); o_v=0, o_d=0, i_b=0.
REQ-025 Reset asserted mid-token (S_LIT or S_RUN) abandons the remaining output without completing it.
REQ-026 The first token may be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro ZLE_DEC_ERR_EN controls the illegal-token check.
REQ-028 Macro defined:
- port err exists.
- A literal token with value 0 (i_d=4'b0000) is accepted (i_b=0) but dropped: state remains S_IDLE, no output.
- err<=1 on that edge and stays set until reset.
REQ-029 Macro undefined:
- no err port.
- A literal 0 is decoded normally as a single zero output.

Verification
REQ-030 Literals 3, 5, 7, each sent with i_v=1 and o_b=0 -> outputs 3, 5, 7 in that order, each one cycle after acceptance, with i_b=1 on each output cycle.
REQ-031 Run token 4'b1111 with o_b=0 -> eight consecutive o_d=0 transfers, then i_b=0.
- Run token 4'b1000 -> exactly one zero transfer.
REQ-032 Run token 4'b1010 with o_b=1 for cycles 2-4 after acceptance -> exactly three zero transfers in total; o_v held at 1 during the stall; no token accepted until the run ends.
REQ-033 Reset pulsed low during the 2nd zero of a 4'b1111 run -> o_v=0 immediately; after release, token 4'b0110 -> single output 6.
REQ-034 Token 4'b0000 -> with ZLE_DEC_ERR_EN defined: no output and err=1 until reset; undefined: one output of 0 and no err port.
